shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 Start  input  1  request valid; operands below are sampled when Start & InReady.
REQ-005 InReady  output  1  high only in IDLE; request accepted when Start & InReady.
REQ-006 ShiftType  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-007 Amount  input  8  register-specified shift amount (Rs[7:0]).
REQ-008 Operand  input  32  value to shift.
REQ-009 CarryIn  input  1  current C flag.
REQ-010 Flush  input  1  synchronous abort of any in-flight operation.
REQ-011 Busy  output  1  high in SHIFT or DONE.
REQ-012 OutValid  output  1  high in DONE; Result/CarryOut valid.
REQ-013 OutReady  input  1  consumer accepts the result when OutValid & OutReady.
REQ-014 Result  output  32  shifted value.
REQ-015 CarryOut  output  1  shifter carry-out.

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-017 On acceptance, the block SHALL capture Operand into a working register, CarryIn into a carry register, ShiftType, and an effective count E.
REQ-018 E SHALL be min(Amount,33) for LSL/LSR/ASR. For ROR, E SHALL be 0 if Amount==0, 32 if Amount!=0 and Amount[4:0]==0, and Amount[4:0] otherwise.
REQ-019 IDLE -> DONE when accepted with E==0; IDLE -> SHIFT with count=E when accepted with E>0.
REQ-020 Each SHIFT cycle SHALL shift the working register by exactly one bit and decrement count.
REQ-021 Each SHIFT cycle SHALL load the carry register with the bit shifted out: bit31 for LSL, bit0 for LSR/ASR/ROR.
REQ-022 Fill per SHIFT cycle: LSL and LSR shift in 0; ASR shifts in bit31; ROR shifts in the old bit0 at bit31.
REQ-023 SHIFT -> DONE on the cycle in which count decrements from 1 to 0.
REQ-024 Latency: for acceptance at edge T, OutValid SHALL rise after edge T+1+E (E==0 gives OutValid one cycle after acceptance).
REQ-025 In DONE, Result and CarryOut SHALL hold stable while OutReady is low; DONE -> IDLE on OutValid & OutReady.
REQ-026 No new request SHALL be accepted in the DONE-handshake cycle; InReady rises the following cycle.
REQ-027 Result/CarryOut SHALL be driven from the working/carry registers in all states.
REQ-028 Outside DONE, Result/CarryOut contents SHALL be don't-care to consumers.
REQ-029 Flush high SHALL force IDLE at the next edge from any state, clear OutValid, and discard the operation.
REQ-030 Flush SHALL take priority over both Start and OutReady in the same cycle.
REQ-031 Start while not InReady SHALL be ignored; the requester holds Start and the operands until accepted.

Reset
REQ-032 reset low SHALL asynchronously force IDLE, count=0, working register=0, carry=0, OutValid=0, Busy=0; InReady SHALL read 1.
REQ-033 A reset asserted mid-SHIFT or in DONE SHALL discard the operation; after release, no OutValid occurs until a new request is accepted.

Verification
REQ-034 LSL, Amount=4, Operand=0x000000FF, CarryIn=0 -> Result=0x00000FF0, CarryOut=0, OutValid 5 cycles after accept.
REQ-035 LSR, Amount=32, Operand=0x80000001 -> Result=0x00000000, CarryOut=1. ASR, Amount=40, Operand=0x80000000 -> Result=0xFFFFFFFF, CarryOut=1, after 33 SHIFT cycles.
REQ-036 ROR, Amount=0x20, Operand=0x80000001 -> Result=0x80000001, CarryOut=1. ROR, Amount=0, CarryIn=1 -> Operand unchanged, CarryOut=1, OutValid 1 cycle after accept.
REQ-037 LSL, Amount=33, Operand=0xFFFFFFFF -> Result=0, CarryOut=0. LSR, Amount=200 -> Result=0, CarryOut=0, 33 SHIFT cycles.
REQ-038 Hold OutReady low 10 cycles in DONE -> Result/OutValid stable. Assert Flush in SHIFT with Start high -> IDLE next cycle, request not accepted, no OutValid.
REQ-039 Assert reset in SHIFT -> immediate IDLE/OutValid=0. After release, a fresh LSL 1 of 0x1 -> Result=0x2.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-shift sequencer: applies an LSL/LSR/ASR/ROR one bit per cycle
// and returns the result and carry-out via a ready/valid handshake.
module shift_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    output logic        InReady,
    input  logic [1:0]  ShiftType,
    input  logic [7:0]  Amount,
    input  logic [31:0] Operand,
    input  logic        CarryIn,
    input  logic        Flush,
    output logic        Busy,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] Result,
    output logic        CarryOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } shift_t;

    state_t      state;
    shift_t      stype;
    logic [5:0]  count;
    logic [31:0] work;
    logic        carry;
    logic [5:0]  eff;
    logic        accept;

    // Effective step count: 33 steps fully drain the register for linear shifts,
    // while rotates only ever need up to 32.
    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        eff = 6'd0;
        if (ShiftType == ROR) begin
            if (Amount == 8'd0)
                eff = 6'd0;
            else if (Amount[4:0] == 5'd0)
                eff = 6'd32;
            else
                eff = {1'b0, Amount[4:0]};
        end else if (Amount > 8'd33) begin
            eff = 6'd33;
        end else begin
            eff = Amount[5:0];
        end
    end

    assign accept   = Start & InReady;
    assign Result   = work;
    assign CarryOut = carry;

    // OutValid trails entry into DONE by one cycle, which gives a latency of 1+E.
    // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            stype    <= LSL;
            count    <= 6'd0;
            work     <= 32'd0;
            carry    <= 1'b0;
            InReady  <= 1'b1;
            Busy     <= 1'b0;
            OutValid <= 1'b0;
        end else if (Flush) begin
            state    <= IDLE;
            count    <= 6'd0;
            InReady  <= 1'b1;
            Busy     <= 1'b0;
            OutValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        work    <= Operand;
                        carry   <= CarryIn;
                        stype   <= shift_t'(ShiftType);
                        count   <= eff;
                        InReady <= 1'b0;
                        Busy    <= 1'b1;
                        state   <= (eff == 6'd0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    case (stype)
                        LSL: begin
                            carry <= work[31];
                            work  <= {work[30:0], 1'b0};
                        end
                        LSR: begin
                            carry <= work[0];
                            work  <= {1'b0, work[31:1]};
                        end
                        ASR: begin
                            carry <= work[0];
                            work  <= {work[31], work[31:1]};
                        end
                        default: begin
                            carry <= work[0];
                            work  <= {work[0], work[31:1]};
                        end
                    endcase
                    count <= count - 6'd1;
                    if (count == 6'd1)
                        state <= DONE;
                end
                DONE: begin
                    if (!OutValid) begin
                        OutValid <= 1'b1;
                    end else if (OutReady) begin
                        state    <= IDLE;
                        OutValid <= 1'b0;
                        Busy     <= 1'b0;
                        InReady  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer: shift kinds, amount clamping,
// latency, output hold, flush and mid-operation reset.
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        Start;
    logic        InReady;
    logic [1:0]  ShiftType;
    logic [7:0]  Amount;
    logic [31:0] Operand;
    logic        CarryIn;
    logic        Flush;
    logic        Busy;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Result;
    logic        CarryOut;

    int total;
    int bad;

    shift_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .InReady   (InReady),
        .ShiftType (ShiftType),
        .Amount    (Amount),
        .Operand   (Operand),
        .CarryIn   (CarryIn),
        .Flush     (Flush),
        .Busy      (Busy),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .Result    (Result),
        .CarryOut  (CarryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, measure edges from acceptance to OutValid, then complete the handshake.
    task automatic run_op(input string tag, input logic [1:0] st, input logic [7:0] amt,
                          input logic [31:0] op, input logic cin,
                          input logic [31:0] exp_res, input logic exp_c, input int exp_lat);
        int n;
        check({tag, "_inready"}, {31'd0, InReady}, 32'd1);
        ShiftType = st;
        Amount    = amt;
        Operand   = op;
        CarryIn   = cin;
        Start     = 1'b1;
        tick();
        Start = 1'b0;
        n = 0;
        while (!OutValid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_result"}, Result, exp_res);
        check({tag, "_carry"}, {31'd0, CarryOut}, {31'd0, exp_c});
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        check({tag, "_post_idle"}, {30'd0, OutValid, InReady}, 32'd1);
    endtask

    initial begin
        int seen_valid;
        logic [31:0] held_res;
        logic        held_c;

        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        Start     = 1'b0;
        ShiftType = 2'b00;
        Amount    = 8'd0;
        Operand   = 32'd0;
        CarryIn   = 1'b0;
        Flush     = 1'b0;
        OutReady  = 1'b0;

        #12;
        check("rst_inready", {31'd0, InReady}, 32'd1);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_outvalid", {31'd0, OutValid}, 32'd0);
        check("rst_result", Result, 32'd0);
        check("rst_carry", {31'd0, CarryOut}, 32'd0);
        reset = 1'b1;
        tick();

        run_op("lsl4",    2'b00, 8'd4,    32'h0000_00FF, 1'b0, 32'h0000_0FF0, 1'b0, 5);
        run_op("lsr32",   2'b01, 8'd32,   32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1, 33);
        run_op("asr40",   2'b10, 8'd40,   32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 34);
        run_op("ror32",   2'b11, 8'h20,   32'h8000_0001, 1'b0, 32'h8000_0001, 1'b1, 33);
        run_op("ror0",    2'b11, 8'd0,    32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1);
        run_op("lsl33",   2'b00, 8'd33,   32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 34);
        run_op("lsr200",  2'b01, 8'd200,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 34);
        run_op("ror4",    2'b11, 8'h24,   32'h0000_00F1, 1'b0, 32'h1000_000F, 1'b0, 5);
        run_op("asr3",    2'b10, 8'd3,    32'h7000_0004, 1'b0, 32'h0E00_0000, 1'b1, 4);
        run_op("lsl0",    2'b00, 8'd0,    32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1, 1);

        // Result and OutValid must hold while the consumer stalls.
        ShiftType = 2'b01;
        Amount    = 8'd8;
        Operand   = 32'hA5A5_0000;
        CarryIn   = 1'b0;
        Start     = 1'b1;
        tick();
        Start = 1'b0;
        repeat (9) tick();
        check("hold_valid0", {31'd0, OutValid}, 32'd1);
        check("hold_result0", Result, 32'h00A5_A500);
        held_res = Result;
        held_c   = CarryOut;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", {31'd0, OutValid}, 32'd1);
            check("hold_result", Result, 32'h00A5_A500);
            check("hold_carry", {31'd0, CarryOut}, {31'd0, held_c});
        end
        check("hold_busy", {31'd0, Busy}, 32'd1);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        check("hold_release", {30'd0, OutValid, InReady}, 32'd1);

        // Flush mid-SHIFT beats a simultaneous Start; nothing comes out afterwards.
        ShiftType = 2'b00;
        Amount    = 8'd10;
        Operand   = 32'h0000_0001;
        Start     = 1'b1;
        tick();
        Start = 1'b0;
        repeat (3) tick();
        check("flush_pre_busy", {31'd0, Busy}, 32'd1);
        Flush     = 1'b1;
        Start     = 1'b1;
        ShiftType = 2'b00;
        Amount    = 8'd0;
        tick();
        Flush = 1'b0;
        Start = 1'b0;
        check("flush_idle", {29'd0, InReady, Busy, OutValid}, 32'd4);
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (OutValid || Busy) seen_valid++;
        end
        check("flush_no_output", seen_valid, 0);

        // Asynchronous reset mid-SHIFT discards the operation immediately.
        ShiftType = 2'b01;
        Amount    = 8'd20;
        Operand   = 32'hFFFF_0000;
        Start     = 1'b1;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        #2;
        reset = 1'b0;
        #1;
        check("arst_state", {29'd0, InReady, Busy, OutValid}, 32'd4);
        check("arst_result", Result, 32'd0);
        check("arst_carry", {31'd0, CarryOut}, 32'd0);
        #10;
        reset = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (OutValid || Busy) seen_valid++;
        end
        check("arst_no_output", seen_valid, 0);
        run_op("post_rst_lsl1", 2'b00, 8'd1, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
